// File: rtl/ex_stage_pkg.sv
// arvi_ex_pkg: shared types, constants and helpers for the ARVI execute stage.
package arvi_ex_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_PASSB, ALU_AUIPC,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_t;
  typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV, MD_DONE} md_state_t;
  typedef struct packed {
    logic            valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] res;
    logic            z;
    logic [XLEN-1:0] wr_data;
    logic [XLEN-1:0] pc_jump;
    logic            illegal;
  } exmem_t;
  localparam exmem_t EXMEM_BUBBLE = '{valid: 1'b0, inst: NOP_INST, pc: '0, res: '0, z: 1'b0,
                                     wr_data: '0, pc_jump: '0, illegal: 1'b0};
  function automatic logic is_muldiv(input alu_op_t op);
    return op >= ALU_MUL;
  endfunction
endpackage

// File: rtl/ex_stage_muldiv.sv
// muldiv: multi-cycle RV32M unit; one-cycle product register and a 32-step restoring divider.
module muldiv
  import arvi_ex_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  input  logic            hold,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  md_state_t state_q, state_d;
  alu_op_t op_q, op_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic qneg_q, qneg_d, rneg_q, rneg_d;
  logic sa, sb;
  logic signed [XLEN:0] ea, eb;
  logic signed [2*XLEN-1:0] prod;
  logic [XLEN:0] rem_t, rem_s;
  logic [XLEN-1:0] quo, rem;
  always_comb begin
    sa = (op == ALU_DIV || op == ALU_REM) & a[XLEN-1];
    sb = (op == ALU_DIV || op == ALU_REM) & b[XLEN-1];
    ea = {(op != ALU_MULHU) & a[XLEN-1], a};
    eb = {(op == ALU_MUL || op == ALU_MULH) & b[XLEN-1], b};
    prod = 64'(ea) * 64'(eb);
    rem_t = acc_q[2*XLEN-1:XLEN-1];
    rem_s = rem_t - {1'b0, dvs_q};
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    dvs_d = dvs_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    case (state_q)
      MD_IDLE: if (start) begin
        op_d = op;
        if (op <= ALU_MULHU) begin
          acc_d = prod;
          state_d = MD_MUL;
        end else begin
          // Divide on magnitudes; a zero divisor keeps the all-ones quotient unsigned.
          acc_d = {{XLEN{1'b0}}, sa ? -a : a};
          dvs_d = sb ? -b : b;
          qneg_d = (sa ^ sb) & (b != '0);
          rneg_d = sa;
          cnt_d = '0;
          state_d = MD_DIV;
        end
      end
      MD_MUL: state_d = hold ? MD_DONE : MD_IDLE;
      MD_DIV: begin
        acc_d = rem_s[XLEN] ? {rem_t[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                            : {rem_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        cnt_d = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
        state_d = (cnt_q == 5'd31) ? MD_DONE : MD_DIV;
      end
      default: state_d = hold ? MD_DONE : MD_IDLE;
    endcase
    if (kill) state_d = MD_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= MD_IDLE;
      op_q <= ALU_ADD;
      cnt_q <= '0;
      acc_q <= '0;
      dvs_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      dvs_q <= dvs_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  // The product is already registered in MUL, so that state can hand over its result.
  assign done = (state_q == MD_MUL) || (state_q == MD_DONE);
  assign busy = start & ~done;
  assign quo = acc_q[XLEN-1:0];
  assign rem = acc_q[2*XLEN-1:XLEN];
  assign result = (op_q == ALU_MUL)   ? acc_q[XLEN-1:0] :
                  (op_q <= ALU_MULHU) ? acc_q[2*XLEN-1:XLEN] :
                  (op_q <= ALU_DIVU)  ? (qneg_q ? -quo : quo) : (rneg_q ? -rem : rem);
endmodule

// File: rtl/ex_stage.sv
// ex_stage: ARVI execute stage with ALU, optional RV32M unit and the EX/MEM pipeline register.
module ex_stage
  import arvi_ex_pkg::*;
#(
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_alusrc,
  input  alu_op_t         i_alu_op,
  input  logic            i_mem_stall,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_valid,
  output logic [31:0]     o_inst,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_alu_res,
  output logic            o_z,
  output logic [XLEN-1:0] o_wr_data,
  output logic [XLEN-1:0] o_pc_jump,
  output logic            o_ex_inst_illegal
);
  logic [XLEN-1:0] b, alu_res, md_res, res;
  logic md_op, md_busy, md_done;
  exmem_t ex_q, ex_d;
  assign b = i_alusrc ? i_imm : i_rs2;
  assign md_op = i_valid & is_muldiv(i_alu_op);
  always_comb begin
    alu_res = '0;
    case (i_alu_op)
      ALU_ADD:   alu_res = i_rs1 + b;
      ALU_SUB:   alu_res = i_rs1 - b;
      ALU_AND:   alu_res = i_rs1 & b;
      ALU_OR:    alu_res = i_rs1 | b;
      ALU_XOR:   alu_res = i_rs1 ^ b;
      ALU_SLL:   alu_res = i_rs1 << b[4:0];
      ALU_SRL:   alu_res = i_rs1 >> b[4:0];
      ALU_SRA:   alu_res = $signed(i_rs1) >>> b[4:0];
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(i_rs1) < $signed(b)};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, i_rs1 < b};
      ALU_PASSB: alu_res = b;
      ALU_AUIPC: alu_res = i_pc + b;
      default:   alu_res = '0;
    endcase
  end
  generate
    if (MULDIV_EN) begin : g_md
      muldiv u_muldiv (
        .clk(i_clk), .rst_n(i_rst), .start(md_op), .op(i_alu_op), .a(i_rs1), .b(b),
        .kill(i_flush), .hold(i_mem_stall), .busy(md_busy), .done(md_done), .result(md_res)
      );
    end else begin : g_no_md
      assign md_busy = 1'b0;
      assign md_done = 1'b0;
      assign md_res = '0;
    end
  endgenerate
  assign o_stall = md_busy;
  assign res = (md_op & md_done) ? md_res : alu_res;
  always_comb begin
    ex_d = ex_q;
    if (i_flush || (!i_mem_stall && md_busy)) ex_d = EXMEM_BUBBLE;
    else if (!i_mem_stall) begin
      ex_d.valid = i_valid;
      ex_d.inst = i_inst;
      ex_d.pc = i_pc;
      ex_d.res = res;
      ex_d.z = (res == '0);
      ex_d.wr_data = i_rs2;
      ex_d.pc_jump = i_pc + i_imm;
      ex_d.illegal = md_op & ~MULDIV_EN;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) ex_q <= EXMEM_BUBBLE;
    else ex_q <= ex_d;
  assign o_valid = ex_q.valid;
  assign o_inst = ex_q.inst;
  assign o_pc = ex_q.pc;
  assign o_alu_res = ex_q.res;
  assign o_z = ex_q.z;
  assign o_wr_data = ex_q.wr_data;
  assign o_pc_jump = ex_q.pc_jump;
  assign o_ex_inst_illegal = ex_q.illegal;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors with hand-computed expectations for ex_stage.
module tb_ex_stage;
  import arvi_ex_pkg::*;
  logic i_clk = 1'b0, i_rst = 1'b0, i_valid = 1'b0, i_alusrc = 1'b0;
  logic i_mem_stall = 1'b0, i_flush = 1'b0;
  logic [31:0] i_inst = NOP_INST, i_pc = '0, i_rs1 = '0, i_rs2 = '0, i_imm = '0;
  alu_op_t i_alu_op = ALU_ADD;
  logic o_stall, o_valid, o_z, o_ex_inst_illegal;
  logic [31:0] o_inst, o_pc, o_alu_res, o_wr_data, o_pc_jump;
  int vectors = 0, miscompares = 0;

  ex_stage #(.MULDIV_EN(1'b1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_inst(i_inst), .i_pc(i_pc),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .i_alusrc(i_alusrc), .i_alu_op(i_alu_op),
    .i_mem_stall(i_mem_stall), .i_flush(i_flush), .o_stall(o_stall), .o_valid(o_valid),
    .o_inst(o_inst), .o_pc(o_pc), .o_alu_res(o_alu_res), .o_z(o_z), .o_wr_data(o_wr_data),
    .o_pc_jump(o_pc_jump), .o_ex_inst_illegal(o_ex_inst_illegal)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input alu_op_t op, input logic [31:0] a, input logic [31:0] bb,
                       input logic src, input logic [31:0] imm);
    i_valid = 1'b1;
    i_alu_op = op;
    i_rs1 = a;
    i_rs2 = bb;
    i_alusrc = src;
    i_imm = imm;
    i_inst = {27'h5A5A5A5, op};
  endtask

  task automatic alu(input string tag, input alu_op_t op, input logic [31:0] a,
                     input logic [31:0] bb, input logic src, input logic [31:0] imm,
                     input logic [31:0] exp);
    issue(op, a, bb, src, imm);
    tick();
    chk(tag, o_alu_res, exp);
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
    i_valid = 1'b0;
  endtask

  task automatic md(input string tag, input alu_op_t op, input logic [31:0] a,
                    input logic [31:0] bb, input int exp_stalls, input logic [31:0] exp);
    int n;
    issue(op, a, bb, 1'b0, 32'd0);
    #1;
    n = 0;
    while (o_stall && n < 100) begin
      n++;
      tick();
    end
    chk({tag, "_stalls"}, n, exp_stalls);
    chk({tag, "_bubble"}, {31'd0, o_valid}, 32'd0);
    tick();
    chk(tag, o_alu_res, exp);
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
    i_valid = 1'b0;
  endtask

  initial begin
    int n;
    tick();
    tick();
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_inst", o_inst, 32'h0000_0013);
    chk("rst_res", o_alu_res, 32'd0);
    chk("rst_pcjump", o_pc_jump, 32'd0);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    i_rst = 1'b1;
    tick();

    i_pc = 32'h100;
    issue(ALU_ADD, 32'd5, 32'hFFFF_FFFB, 1'b0, 32'h20);
    tick();
    chk("add_res", o_alu_res, 32'd0);
    chk("add_z", {31'd0, o_z}, 32'd1);
    chk("add_inst", o_inst, 32'hB4B4_B4A0);
    chk("add_pc", o_pc, 32'h100);
    chk("add_wdata", o_wr_data, 32'hFFFF_FFFB);
    chk("add_pcjump", o_pc_jump, 32'h120);
    chk("add_illegal", {31'd0, o_ex_inst_illegal}, 32'd0);
    i_valid = 1'b0;

    alu("sra", ALU_SRA, 32'h8000_0000, 32'd0, 1'b1, 32'd4, 32'hF800_0000);
    chk("sra_z", {31'd0, o_z}, 32'd0);
    alu("srl", ALU_SRL, 32'h8000_0000, 32'd4, 1'b0, 32'd0, 32'h0800_0000);
    alu("sll", ALU_SLL, 32'h0000_0003, 32'd33, 1'b0, 32'd0, 32'h0000_0006);
    alu("sub", ALU_SUB, 32'd3, 32'd5, 1'b0, 32'd0, 32'hFFFF_FFFE);
    alu("xor", ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'd0, 32'h0FF0_0FF0);
    alu("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd1);
    alu("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd0);
    alu("passb", ALU_PASSB, 32'd7, 32'd9, 1'b1, 32'h1234_5000, 32'h1234_5000);
    i_pc = 32'h1000;
    alu("auipc", ALU_AUIPC, 32'd0, 32'd0, 1'b1, 32'h2000, 32'h3000);

    md("divu", ALU_DIVU, 32'd100, 32'd7, 33, 32'd14);
    md("rem_neg", ALU_REM, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF);
    md("div_neg", ALU_DIV, 32'hFFFF_FFEC, 32'd3, 33, 32'hFFFF_FFFA);
    md("div_zero", ALU_DIV, 32'd5, 32'd0, 33, 32'hFFFF_FFFF);
    md("rem_zero", ALU_REM, 32'hFFFF_FFF9, 32'd0, 33, 32'hFFFF_FFF9);
    md("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000);
    md("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0);
    md("mulh", ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'd0);
    md("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE);
    md("mul", ALU_MUL, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB);
    md("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'd2, 1, 32'hFFFF_FFFF);

    issue(ALU_DIV, 32'd1000, 32'd3, 1'b0, 32'd0);
    #1;
    chk("flush_stall_on", {31'd0, o_stall}, 32'd1);
    repeat (9) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    issue(ALU_ADD, 32'd40, 32'd2, 1'b0, 32'd0);
    #1;
    chk("flush_stall_off", {31'd0, o_stall}, 32'd0);
    chk("flush_valid", {31'd0, o_valid}, 32'd0);
    chk("flush_inst", o_inst, 32'h0000_0013);
    tick();
    chk("post_flush_add", o_alu_res, 32'd42);
    chk("post_flush_valid", {31'd0, o_valid}, 32'd1);
    i_valid = 1'b0;
    md("post_flush_divu", ALU_DIVU, 32'd100, 32'd7, 33, 32'd14);

    issue(ALU_DIVU, 32'd100, 32'd7, 1'b0, 32'd0);
    #1;
    n = 0;
    while (o_stall && n < 100) begin
      n++;
      tick();
    end
    chk("mstall_stalls", n, 33);
    i_mem_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mstall_hold_valid", {31'd0, o_valid}, 32'd0);
      chk("mstall_hold_res", o_alu_res, 32'd0);
      chk("mstall_no_stall", {31'd0, o_stall}, 32'd0);
    end
    i_mem_stall = 1'b0;
    tick();
    chk("mstall_res", o_alu_res, 32'd14);
    chk("mstall_valid", {31'd0, o_valid}, 32'd1);
    i_valid = 1'b0;

    i_pc = 32'h200;
    alu("pre_rst_add", ALU_ADD, 32'h10, 32'h20, 1'b0, 32'h40, 32'h30);
    i_mem_stall = 1'b1;
    issue(ALU_DIV, 32'd50, 32'd5, 1'b0, 32'd0);
    repeat (5) tick();
    chk("rst_mid_held", o_alu_res, 32'h30);
    chk("rst_mid_held_pcj", o_pc_jump, 32'h240);
    #1 i_rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, o_valid}, 32'd0);
    chk("arst_inst", o_inst, 32'h0000_0013);
    chk("arst_res", o_alu_res, 32'd0);
    chk("arst_pc", o_pc, 32'd0);
    chk("arst_pcjump", o_pc_jump, 32'd0);
    chk("arst_wdata", o_wr_data, 32'd0);
    i_valid = 1'b0;
    i_mem_stall = 1'b0;
    tick();
    i_rst = 1'b1;
    tick();
    md("post_rst_mul", ALU_MUL, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
